// File: rtl/ip_scc_arb_pkg.sv
// rtl/ip_scc_arb_pkg.sv - shared types and constants for the SCC bank RAM arbiter
//
// Purpose: arbiter FSM state encoding, latency counter width, default
// memory address width. Imported by every arbiter file.
package ip_scc_arb_pkg;

  // Default RAM address width (16 KiB SCC bank RAM).
  localparam int unsigned ARB_ADDR_W = 14;

  // Read latency counter width; holds MEM_RD_LATENCY values 1..3.
  localparam int unsigned LAT_CNT_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_BUS_ACC  = 3'd1,
    ST_BUS_WAIT = 3'd2,
    ST_AUX_ACC  = 3'd3,
    ST_AUX_WAIT = 3'd4
  } arb_state_e;

endpackage

// File: rtl/ip_scc_arb_lat_counter.sv
// rtl/ip_scc_arb_lat_counter.sv - loadable down-counter timing the RAM read latency
//
// Purpose: counts the clocks between a read strobe and valid RAM data.
// Shared by the bus and aux wait states.
// Ports:
//   clk_i, reset_i  clock, synchronous active-high reset
//   load_i          load load_val_i (takes priority over counting)
//   load_val_i      number of wait clocks to time
//   done_o          last wait clock (count at 1 or 0)
module ip_scc_arb_lat_counter
  import ip_scc_arb_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 load_i,
  input  logic [LAT_CNT_W-1:0] load_val_i,
  output logic                 done_o
);

  logic [LAT_CNT_W-1:0] count_q;
  logic [LAT_CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - LAT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Loaded with N on entry to a wait state: done in the Nth wait clock.
  assign done_o = (count_q <= LAT_CNT_W'(1));

endmodule

// File: rtl/ip_scc_memory_arbiter.sv
// rtl/ip_scc_memory_arbiter.sv - SCC bank RAM arbiter, MSX bus priority plus aux port
//
// Purpose: shares the single-port SCC bank RAM between the MSX bus (fixed
// priority, one strobe per bus cycle, read data held for the rest of the
// cycle) and an auxiliary loader/debug port (req/ack handshake) that uses
// idle memory cycles.
// Optional: `define IP_SCC_ARB_WRITE_PROTECT_EN adds bus_wp_i; protected bus
// writes walk through BUS_ACC without any RAM strobe.
// Ports:
//   clk_i, reset_i                      clock, synchronous active-high reset
//   bus_active_i/bus_wr_i/bus_address_i/bus_wdata_i  MSX bus cycle inputs
//   bus_wp_i (optional)                 bus write protect
//   bus_rdata_o/bus_rdata_en_o          held bus read data and valid
//   aux_req_i/aux_wr_i/aux_address_i/aux_wdata_i     aux request inputs
//   aux_ack_o/aux_rdata_o/aux_rdata_valid_o          aux handshake and read data
//   mem_n_cs_o/mem_n_rd_o/mem_n_wr_o    RAM strobes, active-low
//   mem_address_o/mem_wdata_o/mem_rdata_i            RAM address and data
module ip_scc_memory_arbiter
  import ip_scc_arb_pkg::*;
#(
  parameter int unsigned MEM_RD_LATENCY = 1,
  parameter int unsigned ADDR_W         = ARB_ADDR_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              bus_active_i,
  input  logic              bus_wr_i,
`ifdef IP_SCC_ARB_WRITE_PROTECT_EN
  input  logic              bus_wp_i,
`endif
  input  logic [ADDR_W-1:0] bus_address_i,
  input  logic [7:0]        bus_wdata_i,
  output logic [7:0]        bus_rdata_o,
  output logic              bus_rdata_en_o,
  input  logic              aux_req_i,
  input  logic              aux_wr_i,
  input  logic [ADDR_W-1:0] aux_address_i,
  input  logic [7:0]        aux_wdata_i,
  output logic              aux_ack_o,
  output logic [7:0]        aux_rdata_o,
  output logic              aux_rdata_valid_o,
  output logic              mem_n_cs_o,
  output logic              mem_n_rd_o,
  output logic              mem_n_wr_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i
);

  arb_state_e        state_q, state_d;
  logic              bus_active_q;
  logic              bus_pending_q, bus_pending_d;
  logic              acc_wr_q, acc_wr_d;
  logic              mem_n_cs_q, mem_n_cs_d;
  logic              mem_n_rd_q, mem_n_rd_d;
  logic              mem_n_wr_q, mem_n_wr_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [7:0]        bus_rdata_q, bus_rdata_d;
  logic              bus_rdata_en_q, bus_rdata_en_d;
  logic              aux_ack_q, aux_ack_d;
  logic [7:0]        aux_rdata_q, aux_rdata_d;
  logic              aux_rdata_valid_q, aux_rdata_valid_d;

  logic bus_start;
  logic bus_blocked;
  logic lat_load;
  logic lat_done;

  // One access per MSX cycle: only the rising edge of bus_active counts.
  assign bus_start = bus_active_i & ~bus_active_q;

`ifdef IP_SCC_ARB_WRITE_PROTECT_EN
  assign bus_blocked = bus_wr_i & bus_wp_i;
`else
  assign bus_blocked = 1'b0;
`endif

  ip_scc_arb_lat_counter u_lat_counter (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (lat_load),
    .load_val_i (LAT_CNT_W'(MEM_RD_LATENCY)),
    .done_o     (lat_done)
  );

  always_comb begin
    state_d           = state_q;
    bus_pending_d     = bus_pending_q;
    acc_wr_d          = acc_wr_q;
    mem_n_cs_d        = 1'b1;
    mem_n_rd_d        = 1'b1;
    mem_n_wr_d        = 1'b1;
    mem_address_d     = mem_address_q;
    mem_wdata_d       = mem_wdata_q;
    bus_rdata_d       = bus_rdata_q;
    bus_rdata_en_d    = bus_rdata_en_q;
    aux_ack_d         = 1'b0;
    aux_rdata_d       = aux_rdata_q;
    aux_rdata_valid_d = 1'b0;
    lat_load          = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A pending request is only honoured while its bus cycle is alive.
        if (bus_start || (bus_pending_q && bus_active_i)) begin
          state_d       = ST_BUS_ACC;
          bus_pending_d = 1'b0;
          acc_wr_d      = bus_wr_i;
          mem_address_d = bus_address_i;
          mem_wdata_d   = bus_wdata_i;
          if (!bus_blocked) begin
            mem_n_cs_d = 1'b0;
            mem_n_rd_d = bus_wr_i;
            mem_n_wr_d = ~bus_wr_i;
          end
        end else if (aux_req_i) begin
          state_d       = ST_AUX_ACC;
          aux_ack_d     = 1'b1;
          acc_wr_d      = aux_wr_i;
          mem_address_d = aux_address_i;
          mem_wdata_d   = aux_wdata_i;
          mem_n_cs_d    = 1'b0;
          mem_n_rd_d    = aux_wr_i;
          mem_n_wr_d    = ~aux_wr_i;
        end
      end
      ST_BUS_ACC: begin
        if (acc_wr_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_BUS_WAIT;
          lat_load = 1'b1;
        end
      end
      ST_BUS_WAIT: begin
        if (lat_done) begin
          state_d = ST_IDLE;
          if (bus_active_i) begin
            bus_rdata_d    = mem_rdata_i;
            bus_rdata_en_d = 1'b1;
          end
        end
      end
      ST_AUX_ACC: begin
        if (acc_wr_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_AUX_WAIT;
          lat_load = 1'b1;
        end
      end
      ST_AUX_WAIT: begin
        if (lat_done) begin
          state_d           = ST_IDLE;
          aux_rdata_d       = mem_rdata_i;
          aux_rdata_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Bus cycle started while the RAM is busy: remember it for the next IDLE.
    if (bus_start && (state_q != ST_IDLE)) begin
      bus_pending_d = 1'b1;
    end

    // Bus cycle over: drop held data and any access that was never issued.
    if (!bus_active_i) begin
      bus_pending_d  = 1'b0;
      bus_rdata_d    = '0;
      bus_rdata_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q           <= ST_IDLE;
      bus_active_q      <= 1'b0;
      bus_pending_q     <= 1'b0;
      acc_wr_q          <= 1'b0;
      mem_n_cs_q        <= 1'b1;
      mem_n_rd_q        <= 1'b1;
      mem_n_wr_q        <= 1'b1;
      mem_address_q     <= '0;
      mem_wdata_q       <= '0;
      bus_rdata_q       <= '0;
      bus_rdata_en_q    <= 1'b0;
      aux_ack_q         <= 1'b0;
      aux_rdata_q       <= '0;
      aux_rdata_valid_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      bus_active_q      <= bus_active_i;
      bus_pending_q     <= bus_pending_d;
      acc_wr_q          <= acc_wr_d;
      mem_n_cs_q        <= mem_n_cs_d;
      mem_n_rd_q        <= mem_n_rd_d;
      mem_n_wr_q        <= mem_n_wr_d;
      mem_address_q     <= mem_address_d;
      mem_wdata_q       <= mem_wdata_d;
      bus_rdata_q       <= bus_rdata_d;
      bus_rdata_en_q    <= bus_rdata_en_d;
      aux_ack_q         <= aux_ack_d;
      aux_rdata_q       <= aux_rdata_d;
      aux_rdata_valid_q <= aux_rdata_valid_d;
    end
  end

  assign bus_rdata_o       = bus_rdata_en_q ? bus_rdata_q : 8'h00;
  assign bus_rdata_en_o    = bus_rdata_en_q;
  assign aux_ack_o         = aux_ack_q;
  assign aux_rdata_o       = aux_rdata_q;
  assign aux_rdata_valid_o = aux_rdata_valid_q;
  assign mem_n_cs_o        = mem_n_cs_q;
  assign mem_n_rd_o        = mem_n_rd_q;
  assign mem_n_wr_o        = mem_n_wr_q;
  assign mem_address_o     = mem_address_q;
  assign mem_wdata_o       = mem_wdata_q;

endmodule

// File: tb/tb_ip_scc_memory_arbiter.sv
// tb/tb_ip_scc_memory_arbiter.sv - self-checking bench for the SCC bank RAM arbiter
module tb_ip_scc_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_active, bus_wr;
  logic        bus_wp;
  logic [13:0] bus_address;
  logic [7:0]  bus_wdata, bus_rdata;
  logic        bus_rdata_en;
  logic        aux_req, aux_wr;
  logic [13:0] aux_address;
  logic [7:0]  aux_wdata, aux_rdata;
  logic        aux_ack, aux_rdata_valid;
  logic        mem_n_cs, mem_n_rd, mem_n_wr;
  logic [13:0] mem_address;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  always #5 clk = ~clk;

  ip_scc_memory_arbiter #(.MEM_RD_LATENCY(1), .ADDR_W(14)) dut (
    .clk_i(clk), .reset_i(reset),
    .bus_active_i(bus_active), .bus_wr_i(bus_wr),
`ifdef IP_SCC_ARB_WRITE_PROTECT_EN
    .bus_wp_i(bus_wp),
`endif
    .bus_address_i(bus_address), .bus_wdata_i(bus_wdata),
    .bus_rdata_o(bus_rdata), .bus_rdata_en_o(bus_rdata_en),
    .aux_req_i(aux_req), .aux_wr_i(aux_wr), .aux_address_i(aux_address),
    .aux_wdata_i(aux_wdata), .aux_ack_o(aux_ack), .aux_rdata_o(aux_rdata),
    .aux_rdata_valid_o(aux_rdata_valid),
    .mem_n_cs_o(mem_n_cs), .mem_n_rd_o(mem_n_rd), .mem_n_wr_o(mem_n_wr),
    .mem_address_o(mem_address), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // RAM model, one clock read latency.
  logic [7:0] ram [16384];
  always @(posedge clk) begin
    if (!mem_n_cs && !mem_n_wr) ram[mem_address] <= mem_wdata;
    if (!mem_n_cs && !mem_n_rd) mem_rdata <= ram[mem_address];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [7:0]  model [16384];
  logic [7:0]  bus_q[$];
  logic [7:0]  aux_q[$];
  logic [13:0] strobe_addr_q[$];
  int          strobe_cyc_q[$];
  int cyc = 0, cs_cnt = 0, rd_cnt = 0, wr_cnt = 0, ack_cnt = 0;
  int ack_cyc = 0, valid_cyc = 0;
  logic [7:0] last_wdata = 8'h00;
  logic en_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor and scoreboard comparisons.
  always @(negedge clk) begin
    if (!mem_n_cs) begin
      cs_cnt++;
      if (!mem_n_rd) rd_cnt++;
      if (!mem_n_wr) begin wr_cnt++; last_wdata = mem_wdata; end
      strobe_addr_q.push_back(mem_address);
      strobe_cyc_q.push_back(cyc);
      check_eq("strobe_rd_wr_exclusive", 32'(!mem_n_rd && !mem_n_wr), 0);
    end
    if (aux_ack) begin ack_cnt++; ack_cyc = cyc; end
    if (aux_rdata_valid) begin
      valid_cyc = cyc;
      if (aux_q.size() == 0) check_eq("aux_unexpected_valid", 1, 0);
      else check_eq("aux_rdata", aux_rdata, aux_q.pop_front());
    end
    if (bus_rdata_en && !en_prev) begin
      if (bus_q.size() == 0) check_eq("bus_unexpected_en", 1, 0);
      else check_eq("bus_rdata", bus_rdata, bus_q.pop_front());
    end
    en_prev = bus_rdata_en;
  end

  task automatic bus_cycle(input logic wr, input logic wp, input logic [13:0] addr,
                           input logic [7:0] data, input int hold);
    @(posedge clk); #1;
    bus_active = 1'b1; bus_wr = wr; bus_address = addr; bus_wdata = data; bus_wp = wp;
    if (wr) begin
      if (!wp) model[addr] = data;
    end else begin
      bus_q.push_back(model[addr]);
    end
    repeat (hold) @(posedge clk);
    #1; bus_active = 1'b0; bus_wr = 1'b0; bus_wp = 1'b0;
    @(posedge clk); #1;
    check_eq("bus_rdata_en_clear", bus_rdata_en, 0);
    check_eq("bus_rdata_clear", bus_rdata, 0);
  endtask

  task automatic aux_access(input logic wr, input logic [13:0] addr, input logic [7:0] data);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    aux_req = 1'b1; aux_wr = wr; aux_address = addr; aux_wdata = data;
    if (wr) model[addr] = data;
    else aux_q.push_back(model[addr]);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (aux_ack) begin got = 1'b1; break; end
    end
    aux_req = 1'b0;
    check_eq("aux_ack_seen", 32'(got), 1);
    repeat (4) @(posedge clk);
  endtask

  int c0, r0, w0, a0, k;
  bit got6;

  initial begin
    reset = 1'b1; bus_active = 1'b0; bus_wr = 1'b0; bus_wp = 1'b0;
    bus_address = '0; bus_wdata = '0;
    aux_req = 1'b0; aux_wr = 1'b0; aux_address = '0; aux_wdata = '0;
    repeat (3) @(posedge clk); #1;
    check_eq("rst_n_cs", mem_n_cs, 1);
    check_eq("rst_n_rd", mem_n_rd, 1);
    check_eq("rst_n_wr", mem_n_wr, 1);
    check_eq("rst_mem_address", mem_address, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_bus_rdata", bus_rdata, 0);
    check_eq("rst_bus_rdata_en", bus_rdata_en, 0);
    check_eq("rst_aux_ack", aux_ack, 0);
    check_eq("rst_aux_rdata", aux_rdata, 0);
    check_eq("rst_aux_rdata_valid", aux_rdata_valid, 0);
    reset = 1'b0;

    // Aux write of A5, then a timed bus read of it.
    aux_access(1'b1, 14'h0123, 8'hA5);
    r0 = rd_cnt;
    @(posedge clk); #1;
    bus_active = 1'b1; bus_wr = 1'b0; bus_address = 14'h0123;
    bus_q.push_back(model[14'h0123]);
    repeat (2) @(posedge clk); #1;
    check_eq("rd_not_yet_valid", bus_rdata_en, 0);
    @(posedge clk); #1;
    check_eq("rd_valid_3clk", bus_rdata_en, 1);
    check_eq("rd_data_3clk", bus_rdata, 8'hA5);
    repeat (3) @(posedge clk); #1;
    check_eq("rd_held", bus_rdata, 8'hA5);
    bus_active = 1'b0;
    @(posedge clk); #1;
    check_eq("rd_en_cleared", bus_rdata_en, 0);
    check_eq("rd_data_cleared", bus_rdata, 0);
    check_eq("rd_one_strobe", rd_cnt - r0, 1);

    // Long bus write: exactly one write strobe.
    w0 = wr_cnt; c0 = cs_cnt;
    strobe_addr_q.delete(); strobe_cyc_q.delete();
    bus_cycle(1'b1, 1'b0, 14'h1000, 8'h3C, 10);
    check_eq("wr_one_strobe", wr_cnt - w0, 1);
    check_eq("wr_one_cs", cs_cnt - c0, 1);
    check_eq("wr_address", strobe_addr_q[0], 14'h1000);
    check_eq("wr_data", last_wdata, 8'h3C);
    aux_access(1'b0, 14'h1000, 8'h00);

    // Top-of-range address.
    bus_cycle(1'b1, 1'b0, 14'h3FFF, 8'h81, 4);
    aux_access(1'b0, 14'h3FFF, 8'h00);
    bus_cycle(1'b0, 1'b0, 14'h1000, 8'h00, 5);

    // Bus and aux requests in the same IDLE clock.
    strobe_addr_q.delete(); strobe_cyc_q.delete();
    fork
      bus_cycle(1'b0, 1'b0, 14'h0123, 8'h00, 8);
      aux_access(1'b0, 14'h1000, 8'h00);
    join
    check_eq("arb_strobe_count", strobe_addr_q.size(), 2);
    if (strobe_addr_q.size() == 2) begin
      check_eq("arb_bus_first", strobe_addr_q[0], 14'h0123);
      check_eq("arb_aux_second", strobe_addr_q[1], 14'h1000);
      check_eq("arb_ack_delay", ack_cyc - strobe_cyc_q[0], 3);
    end

    // Bus cycle starting during AUX_WAIT.
    got6 = 1'b0;
    @(posedge clk); #1;
    aux_req = 1'b1; aux_wr = 1'b0; aux_address = 14'h3FFF;
    aux_q.push_back(model[14'h3FFF]);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (aux_ack) begin got6 = 1'b1; break; end
    end
    aux_req = 1'b0;
    check_eq("pend_aux_ack_seen", 32'(got6), 1);
    @(posedge clk); #1;
    bus_active = 1'b1; bus_wr = 1'b0; bus_address = 14'h0123;
    bus_q.push_back(model[14'h0123]);
    for (k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (bus_rdata_en) break;
    end
    check_eq("pend_latency_le_4", 32'(k <= 4), 1);
    check_eq("pend_strobe_after_valid", strobe_cyc_q[$] - valid_cyc, 1);
    repeat (2) @(posedge clk); #1;
    bus_active = 1'b0;
    repeat (2) @(posedge clk);

    // Aux request withdrawn before it could be acknowledged.
    a0 = ack_cnt; c0 = cs_cnt;
    @(posedge clk); #1;
    bus_active = 1'b1; bus_wr = 1'b0; bus_address = 14'h1000;
    bus_q.push_back(model[14'h1000]);
    @(posedge clk); #1;
    aux_req = 1'b1; aux_wr = 1'b1; aux_address = 14'h1000; aux_wdata = 8'hEE;
    @(posedge clk); #1;
    aux_req = 1'b0;
    repeat (4) @(posedge clk); #1;
    bus_active = 1'b0;
    repeat (2) @(posedge clk); #1;
    check_eq("withdrawn_no_ack", ack_cnt - a0, 0);
    check_eq("withdrawn_one_cs", cs_cnt - c0, 1);

    // Reset in the middle of BUS_WAIT.
    @(posedge clk); #1;
    bus_active = 1'b1; bus_wr = 1'b0; bus_address = 14'h3FFF;
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_n_cs", mem_n_cs, 1);
    check_eq("midrst_n_rd", mem_n_rd, 1);
    check_eq("midrst_bus_rdata_en", bus_rdata_en, 0);
    check_eq("midrst_mem_address", mem_address, 0);
    bus_active = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    r0 = rd_cnt;
    bus_cycle(1'b0, 1'b0, 14'h1000, 8'h00, 5);
    check_eq("postrst_one_strobe", rd_cnt - r0, 1);

`ifdef IP_SCC_ARB_WRITE_PROTECT_EN
    c0 = cs_cnt;
    bus_cycle(1'b1, 1'b1, 14'h2000, 8'h77, 6);
    check_eq("wp_no_cs", cs_cnt - c0, 0);
    aux_access(1'b1, 14'h2000, 8'h5A);
    aux_access(1'b0, 14'h2000, 8'h00);
    bus_cycle(1'b0, 1'b0, 14'h2000, 8'h00, 5);
`endif

    repeat (4) @(posedge clk);
    check_eq("bus_queue_drained", bus_q.size(), 0);
    check_eq("aux_queue_drained", aux_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ip_scc_memory_arbiter.md
Name: ip_scc_memory_arbiter

Overview:
- Shares the SCC cartridge's single-port bank RAM between two requesters.
  - MSX-bus requester: fixed priority.
  - Auxiliary requester (loader/debug port): request/ack handshake.
- Sits between the SCC wrapper's slot/bank decode and ip_ram.
- Issues exactly one memory strobe per MSX bus cycle and holds read data for the remainder of that bus cycle.
- Auxiliary accesses are fitted into idle memory cycles.

Parameters:
- MEM_RD_LATENCY, 1: clocks from read strobe to valid mem_rdata (1..3).
- ADDR_W, 14: memory address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- bus_active  in  1  MSX bus cycle to RAM bank in progress (decoded CS & (RD|WR)).
- bus_wr  in  1  1 = write cycle, 0 = read; valid while bus_active.
- bus_address  in  ADDR_W  bus address.
- bus_wdata  in  8  bus write data.
- bus_rdata  out  8  held read data; 0 when bus_rdata_en=0.
- bus_rdata_en  out  1  read data valid.
- aux_req  in  1  aux request, level; held until aux_ack.
- aux_wr  in  1  aux write.
- aux_address  in  ADDR_W  aux address.
- aux_wdata  in  8  aux write data.
- aux_ack  out  1  one-cycle pulse: aux access issued.
- aux_rdata  out  8  aux read data, held until next aux read completes.
- aux_rdata_valid  out  1  one-cycle pulse on aux read completion.
- mem_n_cs, mem_n_rd, mem_n_wr  out  1  RAM strobes, active-low.
- mem_address  out  ADDR_W  RAM address.
- mem_wdata  out  8  RAM write data.
- mem_rdata  in  8  RAM read data.

Behaviour:
- Reset values:
  - State IDLE.
  - bus_pending=0.
  - All mem strobes=1.
  - mem_address, mem_wdata, bus_rdata, aux_rdata = 0.
  - bus_rdata_en, aux_ack, aux_rdata_valid = 0.
- bus_start = bus_active & ~bus_active_d (registered previous value; reset value 0). Only one access per bus cycle.
- States:
  - IDLE:
    - If bus_start | bus_pending, go to BUS_ACC and clear bus_pending.
    - Else if aux_req, go to AUX_ACC and pulse aux_ack.
  - BUS_ACC (1 clk):
    - mem_n_cs=0; mem_n_wr=~bus_wr; mem_n_rd=bus_wr.
    - Address and data are registered from the bus inputs.
    - Write goes to IDLE; read goes to BUS_WAIT.
  - BUS_WAIT (MEM_RD_LATENCY clks, down-counter; strobes inactive):
    - At count end, sample mem_rdata into bus_rdata, set bus_rdata_en=1 if bus_active is still 1, go to IDLE.
  - AUX_ACC (1 clk): same strobes as BUS_ACC using aux inputs. Write goes to IDLE; read goes to AUX_WAIT.
  - AUX_WAIT (MEM_RD_LATENCY clks): at end, load aux_rdata, pulse aux_rdata_valid, go to IDLE.
- bus_start in any non-IDLE state sets bus_pending.
- bus_start in IDLE together with aux_req: bus wins; aux waits.
- Worst-case bus strobe latency from bus_start is 2+MEM_RD_LATENCY clks. The wrapper guarantees the MSX cycle is longer.
- bus_active falling:
  - Clears bus_rdata_en and bus_rdata next clock.
  - Clears bus_pending if the access was never issued (aborted cycle).
- Aux requests may be served while bus_active is still high after the bus access completed; bus_rdata is held in the register.
- aux_req deasserted before ack: no access occurs.
- Reset during any state aborts it immediately. A pending aux request is re-arbitrated after reset.

Optional Feature:
- Macro IP_SCC_ARB_WRITE_PROTECT_EN.
- When defined:
  - Adds input bus_wp (1).
  - A bus write with bus_wp=1 passes through BUS_ACC with mem_n_cs=1 (no strobe, no pending, no stall).
  - Aux writes are unaffected.
- When undefined: the port is absent and all bus writes are performed.

Decomposition:
- Shared package ip_scc_arb_pkg:
  - State enum (IDLE, BUS_ACC, BUS_WAIT, AUX_ACC, AUX_WAIT).
  - Latency counter width constant.
  - Default ADDR_W.
- One natural sub-module, ip_scc_arb_lat_counter: loadable down-counter with a done flag, reused by both WAIT states.

Test Plan:
- Bus read only (MEM_RD_LATENCY=1), mem returns 8'hA5: one mem_n_rd pulse; bus_rdata=8'hA5 with bus_rdata_en=1 three clks after bus_start; cleared one clk after bus_active falls.
- Bus write 8'h3C to 14'h1000, bus_active held 10 clks: exactly one mem_n_wr pulse, mem_address=14'h1000.
- bus_start and aux_req in the same IDLE clk: bus strobe first; aux_ack the clk after bus completes.
- bus_start arriving during AUX_WAIT: aux_rdata_valid pulses, then bus strobe issues next clk; bus_rdata valid ≤ 2+MEM_RD_LATENCY+1 clks after bus_start.
- Reset asserted mid BUS_WAIT: next clk all strobes=1, bus_rdata_en=0, bus_pending=0; a new bus_start is served normally.
- With IP_SCC_ARB_WRITE_PROTECT_EN and bus_wp=1: bus write produces no mem_n_cs low; an aux write to the same address succeeds and reads back correctly.
